// File: rtl/crossroad_tlc_monitor.sv
// Crossroad light-bus monitor: checks encoding, exclusion, N>W>S>E order
// and green/yellow durations; latches a sticky fault code for the supervisor.
module crossroad_tlc_monitor #(
    parameter int GREEN_CYC  = 16,
    parameter int YELLOW_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       north_light,
    input  logic [2:0]       south_light,
    input  logic [2:0]       east_light,
    input  logic [2:0]       west_light,
    input  logic             fault_clr,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [1:0]       active_dir,
    output logic             phase,
    output logic             in_sync,
    output logic [CNT_W-1:0] rotations
);
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [CNT_W-1:0] G_LEN   = CNT_W'(GREEN_CYC);
    localparam logic [CNT_W-1:0] Y_LEN   = CNT_W'(YELLOW_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_SYNC, ST_TRACK, ST_FAULT} state_e;

    state_e           state_q, state_d;
    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d;
    logic [1:0]       dir_q, dir_d;
    logic             ph_q, ph_d;
    logic             sync_q, sync_d;
    logic [CNT_W-1:0] rot_q, rot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Indexed by direction code: 0 N, 1 W, 2 S, 3 E
    logic [3:0][2:0] lt;
    logic            enc_err;
    logic [2:0]      nr_cnt;
    logic [1:0]      s_dir;
    logic            s_ph;
    logic            chg;
    logic            legal;
    logic [2:0]      code;

    assign lt = {east_light, south_light, west_light, north_light};

    always_comb begin
        enc_err = 1'b0;
        nr_cnt  = 3'd0;
        s_dir   = 2'd0;
        s_ph    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lt[i] != RED && lt[i] != YEL && lt[i] != GRN) enc_err = 1'b1;
            if (lt[i] != RED) begin
                nr_cnt = nr_cnt + 3'd1;
                s_dir  = 2'(i);
                s_ph   = (lt[i] == YEL);
            end
        end
    end

    assign chg   = (s_dir != dir_q) || (s_ph != ph_q);
    assign legal = ph_q ? (!s_ph && s_dir == dir_q + 2'd1)
                        : (s_ph && s_dir == dir_q);

    // Lowest code wins when several violations hit the same sample
    always_comb begin
        code = 3'd0;
        if (enc_err)               code = 3'd1;
        else if (nr_cnt > 3'd1)    code = 3'd2;
        else if (nr_cnt == 3'd0)   code = 3'd3;
        else if (state_q == ST_TRACK) begin
            if (!chg) begin
                if (!ph_q && cnt_q == G_LEN)      code = 3'd5;
                else if (ph_q && cnt_q == Y_LEN)  code = 3'd6;
            end else if (!legal)                  code = 3'd4;
            else if (!ph_q && cnt_q != G_LEN)     code = 3'd5;
            else if (ph_q && cnt_q != Y_LEN)      code = 3'd6;
        end
    end

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        code_d  = code_q;
        dir_d   = dir_q;
        ph_d    = ph_q;
        sync_d  = sync_q;
        rot_d   = rot_q;
        cnt_d   = cnt_q;
        if (fault_clr) begin
            state_d = ST_SYNC;
            fault_d = 1'b0;
            code_d  = 3'd0;
            sync_d  = 1'b0;
        end else if (state_q != ST_FAULT) begin
            if (code != 3'd0) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
                code_d  = code;
            end else begin
                dir_d = s_dir;
                ph_d  = s_ph;
                if (chg) begin
                    // A legal change out of yellow E can only land on green N
                    if (state_q == ST_TRACK && ph_q && dir_q == 2'd3)
                        rot_d = rot_q + 1'b1;
                    state_d = ST_TRACK;
                    sync_d  = 1'b1;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (state_q == ST_TRACK && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_SYNC;
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            dir_q   <= 2'd0;
            ph_q    <= 1'b0;
            sync_q  <= 1'b0;
            rot_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            dir_q   <= dir_d;
            ph_q    <= ph_d;
            sync_q  <= sync_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign active_dir = dir_q;
    assign phase      = ph_q;
    assign in_sync    = sync_q;
    assign rotations  = rot_q;
endmodule

// File: tb/tb_crossroad_tlc_monitor.sv
// Bench for crossroad_tlc_monitor: directed scenarios plus a randomized
// stream, all compared against a rotation-position reference model.
module tb_crossroad_tlc_monitor;
    localparam int GRN_N = 16;
    localparam int YEL_N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] north_light = 3'b001;
    logic [2:0] south_light = 3'b100;
    logic [2:0] east_light  = 3'b100;
    logic [2:0] west_light  = 3'b100;
    logic       fault_clr   = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] active_dir;
    logic       phase;
    logic       in_sync;
    logic [7:0] rotations;

    crossroad_tlc_monitor #(
        .GREEN_CYC (GRN_N),
        .YELLOW_CYC(YEL_N),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .north_light(north_light),
        .south_light(south_light),
        .east_light (east_light),
        .west_light (west_light),
        .fault_clr  (fault_clr),
        .fault      (fault),
        .fault_code (fault_code),
        .active_dir (active_dir),
        .phase      (phase),
        .in_sync    (in_sync),
        .rotations  (rotations)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state; position = dir*2 + yellow walks 0..7 per rotation
    bit m_fault, m_sync, m_track, m_ph;
    int m_code, m_dir, m_rot, m_cnt;

    logic [15:0] dut_v;
    assign dut_v = {fault, fault_code, active_dir, phase, in_sync, rotations};

    function automatic logic [15:0] mvec();
        return {m_fault, 3'(m_code), 2'(m_dir), m_ph, m_sync, 8'(m_rot)};
    endfunction

    function automatic void model_reset();
        m_fault = 0; m_sync = 0; m_track = 0; m_ph = 0;
        m_code = 0; m_dir = 0; m_rot = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(input logic [11:0] v, input bit clr);
        logic [2:0] l[4];
        int bad, nonred, d, code, cur, nxt, lim;
        bit y;
        l[0] = v[11:9]; l[1] = v[2:0]; l[2] = v[8:6]; l[3] = v[5:3];
        bad = 0; nonred = 0; d = 0; y = 0; code = 0;
        for (int i = 0; i < 4; i++) begin
            if (!(l[i] inside {3'b100, 3'b010, 3'b001})) bad++;
            if (l[i] != 3'b100) begin
                nonred++;
                d = i;
                y = (l[i] == 3'b010);
            end
        end
        if (clr) begin
            m_fault = 0; m_code = 0; m_sync = 0; m_track = 0;
            return;
        end
        if (m_fault) return;
        cur = m_dir * 2 + int'(m_ph);
        nxt = d * 2 + int'(y);
        lim = m_ph ? YEL_N : GRN_N;
        if (bad > 0)          code = 1;
        else if (nonred > 1)  code = 2;
        else if (nonred == 0) code = 3;
        else if (m_track) begin
            if (nxt == cur) begin
                if (m_cnt == lim) code = m_ph ? 6 : 5;
            end else if (nxt != (cur + 1) % 8) code = 4;
            else if (m_cnt != lim) code = m_ph ? 6 : 5;
        end
        if (code != 0) begin
            m_fault = 1;
            m_code  = code;
            return;
        end
        if (nxt != cur) begin
            if (m_track && cur == 7) m_rot = (m_rot + 1) % 256;
            m_track = 1; m_sync = 1; m_cnt = 1;
        end else if (m_track && m_cnt < 255) begin
            m_cnt++;
        end
        m_dir = d;
        m_ph  = y;
    endfunction

    // Packed as {n,s,e,w}; d: 0 N, 1 W, 2 S, 3 E
    function automatic logic [11:0] lights_of(input int d, input bit y);
        logic [2:0] l[4];
        for (int i = 0; i < 4; i++) l[i] = 3'b100;
        l[d] = y ? 3'b010 : 3'b001;
        return {l[0], l[2], l[3], l[1]};
    endfunction

    function automatic logic [11:0] golden(input int k);
        int t;
        t = k % 80;
        return lights_of(t / 20, (t % 20) >= GRN_N);
    endfunction

    task automatic drive(input logic [11:0] v, input bit clr);
        {north_light, south_light, east_light, west_light} = v;
        fault_clr = clr;
        @(posedge clk);
        model_step(v, clr);
        #1;
        fault_clr = 1'b0;
    endtask

    task automatic drive_phase(input int d, input bit y, input int n);
        for (int i = 0; i < n; i++) drive(lights_of(d, y), 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        {north_light, south_light, east_light, west_light} = lights_of(0, 0);
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (dut_v !== 16'h0)
            $display("FAIL reset outputs got=%h want=%h", dut_v, 16'h0);
        else n_pass++;
    endtask

    task automatic test_golden();
        do_reset();
        for (int k = 0; k < 241; k++) begin
            drive(golden(k), 1'b0);
            n_total++;
            if (dut_v !== mvec() || fault !== 1'b0 || in_sync !== (k >= GRN_N))
                $display("FAIL golden cyc=%0d got=%h want=%h", k, dut_v, mvec());
            else n_pass++;
        end
        n_total++;
        if (rotations !== 8'd3)
            $display("FAIL golden_rot got=%0d want=3", rotations);
        else n_pass++;
    endtask

    task automatic test_green_short();
        do_reset();
        drive_phase(0, 0, GRN_N);
        drive_phase(0, 1, YEL_N);
        drive_phase(1, 0, 15);
        n_total++;
        if (fault !== 1'b0)
            $display("FAIL gshort_pre fault got=%b want=0", fault);
        else n_pass++;
        drive_phase(1, 1, 1);
        n_total++;
        if ({fault, fault_code, active_dir, phase, rotations} !== {1'b1, 3'd5, 2'd1, 1'b0, 8'd0})
            $display("FAIL gshort got=%b/%0d/%0d/%b/%0d want=1/5/1/0/0",
                     fault, fault_code, active_dir, phase, rotations);
        else n_pass++;
        drive_phase(2, 0, 3);
        n_total++;
        if (dut_v !== mvec() || fault_code !== 3'd5 || active_dir !== 2'd1)
            $display("FAIL gshort_frozen got=%h want=%h", dut_v, mvec());
        else n_pass++;
    endtask

    task automatic test_conflict();
        do_reset();
        drive_phase(0, 0, GRN_N);
        drive_phase(0, 1, YEL_N);
        drive_phase(1, 0, 3);
        drive({3'b001, 3'b100, 3'b001, 3'b100}, 1'b0);
        n_total++;
        if (fault !== 1'b1 || fault_code !== 3'd2 || dut_v !== mvec())
            $display("FAIL conflict got=%0d want=2", fault_code);
        else n_pass++;
        drive(lights_of(1, 0), 1'b1);
        drive_phase(1, 0, 2);
        drive_phase(1, 1, 1);
        n_total++;
        if (in_sync !== 1'b1 || fault !== 1'b0)
            $display("FAIL conflict_resync got=%b/%b want=1/0", in_sync, fault);
        else n_pass++;
        drive({3'b011, 3'b100, 3'b001, 3'b100}, 1'b0);
        n_total++;
        if (fault_code !== 3'd1 || dut_v !== mvec())
            $display("FAIL enc_prio got=%0d want=1", fault_code);
        else n_pass++;
    endtask

    task automatic test_seq();
        do_reset();
        drive_phase(0, 0, GRN_N);
        drive_phase(0, 1, YEL_N);
        drive_phase(2, 0, 1);
        n_total++;
        if (fault_code !== 3'd4 || dut_v !== mvec())
            $display("FAIL seq got=%0d want=4", fault_code);
        else n_pass++;
        drive(lights_of(0, 1), 1'b1);
        n_total++;
        if (fault !== 1'b0 || in_sync !== 1'b0 || fault_code !== 3'd0)
            $display("FAIL seq_clr got=%b/%b want=0/0", fault, in_sync);
        else n_pass++;
        drive_phase(0, 1, 2);
        n_total++;
        if (in_sync !== 1'b0 || dut_v !== mvec())
            $display("FAIL seq_nosync got=%b want=0", in_sync);
        else n_pass++;
        drive_phase(1, 0, 1);
        n_total++;
        if (in_sync !== 1'b1 || fault !== 1'b0)
            $display("FAIL seq_resync got=%b/%b want=1/0", in_sync, fault);
        else n_pass++;
        drive_phase(1, 0, GRN_N - 1);
        drive_phase(1, 1, YEL_N);
        drive_phase(2, 0, 1);
        n_total++;
        if (fault !== 1'b0 || active_dir !== 2'd2 || dut_v !== mvec())
            $display("FAIL seq_track got=%h want=%h", dut_v, mvec());
        else n_pass++;
    endtask

    task automatic test_yellow_long();
        do_reset();
        for (int d = 0; d < 3; d++) begin
            drive_phase(d, 0, GRN_N);
            drive_phase(d, 1, YEL_N);
        end
        drive_phase(3, 0, GRN_N);
        drive_phase(3, 1, YEL_N);
        n_total++;
        if (fault !== 1'b0)
            $display("FAIL ylong_pre got=%b want=0", fault);
        else n_pass++;
        drive_phase(3, 1, 1);
        n_total++;
        if (fault_code !== 3'd6 || active_dir !== 2'd3 || dut_v !== mvec())
            $display("FAIL ylong got=%0d want=6", fault_code);
        else n_pass++;
        drive(12'b100100100100, 1'b1);
        n_total++;
        if ({fault, fault_code, in_sync} !== 5'b0 || dut_v !== mvec())
            $display("FAIL clr_allred got=%b/%0d/%b want=0/0/0", fault, fault_code, in_sync);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 165; k++) drive(golden(k), 1'b0);
        n_total++;
        if (rotations !== 8'd2 || dut_v !== mvec())
            $display("FAIL midrst_pre rot got=%0d want=2", rotations);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        n_total++;
        if (dut_v !== 16'h0)
            $display("FAIL midrst got=%h want=%h", dut_v, 16'h0);
        else n_pass++;
        rst = 1'b1;
        for (int k = 0; k < 100; k++) begin
            drive(golden(k), 1'b0);
            n_total++;
            if (dut_v !== mvec())
                $display("FAIL midrst_run cyc=%0d got=%h want=%h", k, dut_v, mvec());
            else n_pass++;
        end
        n_total++;
        if ({fault, in_sync, rotations} !== {1'b0, 1'b1, 8'd1})
            $display("FAIL midrst_end got=%b/%b/%0d want=0/1/1", fault, in_sync, rotations);
        else n_pass++;
    endtask

    task automatic test_random();
        int pos, len, idx;
        logic [11:0] v;
        bit clr;
        do_reset();
        pos = 0;
        for (int r = 0; r < 80; r++) begin
            len = (pos % 2 == 1) ? YEL_N : GRN_N;
            if ($urandom_range(0, 5) == 0) len = len + int'($urandom_range(0, 2)) - 1;
            for (int k = 0; k < len; k++) begin
                v = lights_of(pos / 2, pos % 2 == 1);
                if ($urandom_range(0, 79) == 0) begin
                    idx = int'($urandom_range(0, 3));
                    v[idx*3 +: 3] = 3'($urandom_range(0, 7));
                end
                clr = (m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0;
                drive(v, clr);
                n_total++;
                if (dut_v !== mvec())
                    $display("FAIL random r=%0d k=%0d got=%h want=%h", r, k, dut_v, mvec());
                else n_pass++;
            end
            pos = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : (pos + 1) % 8;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_golden();
        test_green_short();
        test_conflict();
        test_seq();
        test_yellow_long();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/crossroad_tlc_monitor.md
Name: crossroad_tlc_monitor

Overview:
- Conflict/compliance monitor on the receiving end of the crossroad traffic-light controller's four light buses.
- Samples north/south/east/west lights every cycle and checks encoding, mutual exclusion, phase order N>W>S>E, and green/yellow durations.
- Latches a sticky fault with a code for the supervisor, and reports the decoded active direction, phase and completed rotations.

Parameters:
GREEN_CYC, 16, cycles a green phase must last exactly
YELLOW_CYC, 4, cycles a yellow phase must last exactly
CNT_W, 8, width of phase counter and rotation counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (asserted when 0)
north_light  input  3  light code: 3'b100 red, 3'b010 yellow, 3'b001 green
south_light  input  3  same encoding
east_light  input  3  same encoding
west_light  input  3  same encoding
fault_clr  input  1  single-cycle pulse; clears fault and returns to SYNC
fault  output  1  sticky fault flag
fault_code  output  3  0 none, 1 ILLEGAL_ENC, 2 CONFLICT, 3 ALL_RED, 4 SEQ, 5 GREEN_TIME, 6 YELLOW_TIME
active_dir  output  2  0 N, 1 W, 2 S, 3 E (direction currently non-red)
phase  output  1  0 green, 1 yellow
in_sync  output  1  1 once a phase boundary has been observed and sequence/timing checks are armed
rotations  output  CNT_W  completed full cycles, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst==0 at clk edge): fault=0, fault_code=0, active_dir=0, phase=0, in_sync=0, rotations=0, phase_cnt=0, state=SYNC. Reset wins over every other input.
- All outputs are registered. A fault detected on a sample is visible one cycle later.
- States: SYNC, TRACK, FAULT.
- Per-sample static checks, armed in SYNC and TRACK:
  - Any light not in {100,010,001} -> code 1.
  - More than one direction non-red -> code 2.
  - All four lights red -> code 3.
- The single non-red direction updates active_dir/phase every clean cycle.
- SYNC: phase_cnt is not checked. On the first change of the (dir,phase) pair -> TRACK, in_sync=1, phase_cnt=1.
- TRACK, same (dir,phase) as the previous sample: phase_cnt++.
  - Green and phase_cnt already equals GREEN_CYC -> code 5 (overrun).
  - Yellow and phase_cnt already equals YELLOW_CYC -> code 6.
- TRACK, (dir,phase) changed:
  - Legal transitions are green(d)->yellow(d) and yellow(d)->green(next(d)), where next is N->W->S->E->N. Anything else -> code 4.
  - Leaving green with phase_cnt != GREEN_CYC -> code 5. Leaving yellow with phase_cnt != YELLOW_CYC -> code 6.
  - On a legal change, phase_cnt=1.
  - Legal yellow(E)->green(N) increments rotations (wraps).
- Priority when several faults occur on one sample: lowest code wins (1>2>3>4>5>6).
- Any fault -> state FAULT, fault=1, fault_code latched. All checks and counters freeze; active_dir/phase hold their last clean values.
- fault_clr==1: fault=0, fault_code=0, in_sync=0, state=SYNC; rotations is retained. fault_clr has priority over any fault detected on the same sample (that sample is ignored). fault_clr outside FAULT also forces SYNC.
- phase_cnt saturates at 2^CNT_W-1.

Test Plan:
- Legal stream, golden sequence from reset (N green 16, N yellow 4, W, S, E ...), monitor and source reset together, run 241 cycles -> fault=0 throughout, in_sync=1 from the cycle after the first N-yellow sample, rotations=3.
- After sync, W green held 15 cycles then W yellow -> fault=1, code=5 one cycle after the first yellow sample; rotations and active_dir=1 frozen.
- After sync, north=001 and east=001 on the same sample -> code=2. Repeat with north=011 plus an east conflict -> code=1 (priority).
- After sync, N yellow for 4 cycles followed by S green -> code=4. Then pulse fault_clr -> fault=0, in_sync=0; the next legal boundary sets in_sync=1 with no fault.
- After sync, E yellow held 5 cycles -> code=6 on the 5th-cycle sample. Fault_clr asserted on the same cycle as an all-red sample -> no fault, state SYNC.
- rst=0 mid-green after 2 rotations -> next edge all outputs 0 and rotations=0; a legal stream afterwards resyncs cleanly.
